widths_struct_arbiter: RTL

//  Shares one widths_struct_mod datapath among NUM_REQ requesters. The datapath is reached through its 12-bit flat wrapper port.
//  - Round-robin arbitration; one transaction in flight at a time.
//  - Captures the datapath result after DP_LAT cycles and returns it with the requester id over a valid/ready response channel.
//  - Sits between the request fabric and the flat datapath instance.

---
 rtl/widths_struct_arbiter_pkg.sv | 25 ++
 rtl/widths_struct_arbiter_rr_arbiter.sv | 32 +++
 rtl/widths_struct_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/widths_struct_arbiter_pkg.sv
// Shared types for the widths_struct arbiter slice: the 12-bit flat payload
// layout (a=[11:4], b=[3:0]), the arbiter FSM state set and a saturating helper.
package widths_struct_pkg;

  localparam int FLAT_W = 12;
  localparam int A_W    = 8;
  localparam int B_W    = 4;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
  } ws_flat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } ws_arb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/widths_struct_arbiter_rr_arbiter.sv
// Combinational round-robin pick: scans upward from last_grant+1 (mod NUM_REQ)
// and returns the first requesting index both one-hot and encoded.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  always_comb begin
    int idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
    any_req = found;
  end

endmodule

// File: rtl/widths_struct_arbiter.sv
// Round-robin front end sharing one flat 12-bit datapath among NUM_REQ requesters.
// Optional statistics counters are built when WIDTHS_STRUCT_ARB_STATS_EN is defined.
module widths_struct_arbiter
  import widths_struct_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DP_LAT  = 1,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FLAT_W-1:0] req_flat,
  output logic [FLAT_W-1:0]         dp_in_flat,
  input  logic [FLAT_W-1:0]         dp_out_flat,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [FLAT_W-1:0]         resp_flat,
  output logic                      busy
`ifdef WIDTHS_STRUCT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt,
  output logic [15:0]               stall_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_CAPT = CAPT;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]         state;
  logic [3:0]         lat_cnt;
  logic               lat_done;
  ws_flat_t           operand;
  ws_flat_t           result;
  ws_flat_t           slot;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant;
  logic               any_req;
  logic               take;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id),
    .any_req    (any_req)
  );

  assign slot      = ws_flat_t'(req_flat[FLAT_W*int'(grant_id) +: FLAT_W]);
  assign take      = (state == ST_IDLE) && any_req;
  assign req_ready = (state == ST_IDLE) ? grant : '0;
  assign lat_done  = (({1'b0, lat_cnt} + 5'd1) == 5'(DP_LAT));

  // Operand stays registered from grant until the FSM returns to IDLE,
  // which keeps the datapath input stable for the whole latency window.
  assign dp_in_flat = operand;
  assign resp_valid = (state == ST_RESP);
  assign resp_flat  = result;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      operand    <= '0;
      result     <= '0;
      resp_id    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            operand    <= slot;
            resp_id    <= grant_id;
            last_grant <= grant_id;
            lat_cnt    <= '0;
            state      <= (DP_LAT == 0) ? ST_CAPT : ST_WAIT;
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_done) state <= ST_CAPT;
        end
        ST_CAPT: begin
          result <= ws_flat_t'(dp_out_flat);
          state  <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WIDTHS_STRUCT_ARB_STATS_EN
  logic [15:0] grant_cnt_r [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_r[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (take && grant[i]) grant_cnt_r[i] <= sat_inc16(grant_cnt_r[i]);
      end
      if ((state == ST_RESP) && !resp_ready) stall_cnt <= sat_inc16(stall_cnt);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[16*g +: 16] = grant_cnt_r[g];
  end
`endif

endmodule
